// File: rtl/systolic_fir.sv
`default_nettype none
// ============================================================================
// Module   : systolic_fir
// Purpose  : Transposed-form systolic FIR, NUM_TAPS MAC PEs, one frame of
//            FRAME_LEN samples per start, results streamed to a write port.
//            Define SYSTOLIC_SAT_EN to saturate results to OUT_W (else wrap).
// Revision : 1.0  initial release
// ============================================================================
module systolic_fir #(
    parameter int DATA_W    = 8,
    parameter int NUM_TAPS  = 4,
    parameter int FRAME_LEN = 16,
    parameter int OUT_W     = 16,
    parameter int ADDR_W    = 14,
    parameter int BASE_ADDR = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic signed [DATA_W-1:0]    in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        coef_we,
    input  logic [$clog2(NUM_TAPS)-1:0] coef_idx,
    input  logic signed [DATA_W-1:0]    coef_data,
    output logic [OUT_W-1:0]            sum_out,
    output logic [ADDR_W-1:0]           ws,
    output logic                        we,
    output logic                        busy,
    output logic                        sys_finish
);
    localparam int ACC_W = 2 * DATA_W + $clog2(NUM_TAPS);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0]  C_LAST_IN = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  C_FRAME   = CNT_W'(FRAME_LEN);
    localparam logic [ADDR_W-1:0] C_BASE    = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic signed [DATA_W-1:0] coef_q [NUM_TAPS];
    logic signed [ACC_W-1:0]  prod_d [NUM_TAPS];
    logic signed [ACC_W-1:0]  prod_q [NUM_TAPS];
    logic signed [ACC_W-1:0]  psum_q [1:NUM_TAPS-1];
    logic                     prod_vld_q;
    logic [CNT_W-1:0]         in_cnt_q, out_cnt_q;
    logic [ADDR_W-1:0]        addr_q, ws_q;
    logic [OUT_W-1:0]         sum_q;
    logic                     we_q;
    logic                     w_start, w_accept;
    logic [OUT_W-1:0]         w_out;

    assign w_start    = (state_q == S_IDLE) && start;
    assign w_accept   = (state_q == S_RUN) && in_valid;
    assign in_ready   = (state_q == S_RUN);
    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign sys_finish = (state_q == S_DONE);
    assign sum_out    = sum_q;
    assign ws         = ws_q;
    assign we         = we_q;

    // Every PE multiplies the same broadcast sample by its own coefficient.
    generate
        for (genvar k = 0; k < NUM_TAPS; k++) begin : g_pe
            logic signed [2*DATA_W-1:0] w_mul;
            assign w_mul     = coef_q[k] * in_data;
            assign prod_d[k] = {{(ACC_W-2*DATA_W){w_mul[2*DATA_W-1]}}, w_mul};
        end
    endgenerate

`ifdef SYSTOLIC_SAT_EN
    localparam logic [OUT_W-1:0] C_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] C_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    logic signed [ACC_W-1:0] w_y;
    logic [ACC_W-OUT_W:0]    w_hi;
    assign w_y  = prod_q[0] + psum_q[1];
    assign w_hi = w_y[ACC_W-1:OUT_W-1];
    always_comb begin
        w_out = w_y[OUT_W-1:0];
        if (!((&w_hi) || !(|w_hi))) begin
            w_out = w_y[ACC_W-1] ? C_MIN : C_MAX;
        end
    end
`else
    assign w_out = OUT_W'(prod_q[0] + psum_q[1]);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (w_accept && (in_cnt_q == C_LAST_IN)) state_d = S_DRAIN;
            S_DRAIN: if (we_q && (out_cnt_q == C_FRAME)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TAPS; k++) coef_q[k] <= '0;
        end else if ((state_q == S_IDLE) && coef_we && (int'(coef_idx) < NUM_TAPS)) begin
            coef_q[coef_idx] <= coef_data;
        end
    end

    // The partial-sum chain only moves when a product is present, so input gaps stall it intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            prod_vld_q <= 1'b0;
            we_q       <= 1'b0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            addr_q     <= C_BASE;
            ws_q       <= C_BASE;
            sum_q      <= '0;
            for (int k = 0; k < NUM_TAPS; k++) prod_q[k] <= '0;
            for (int k = 1; k < NUM_TAPS; k++) psum_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            prod_vld_q <= w_accept;
            we_q       <= prod_vld_q;
            if (w_accept) begin
                for (int k = 0; k < NUM_TAPS; k++) prod_q[k] <= prod_d[k];
                in_cnt_q <= in_cnt_q + CNT_W'(1);
            end
            if (w_start) begin
                in_cnt_q  <= '0;
                out_cnt_q <= '0;
                addr_q    <= C_BASE;
                for (int k = 1; k < NUM_TAPS; k++) psum_q[k] <= '0;
            end else if (prod_vld_q) begin
                for (int k = 1; k < NUM_TAPS - 1; k++) psum_q[k] <= prod_q[k] + psum_q[k+1];
                psum_q[NUM_TAPS-1] <= prod_q[NUM_TAPS-1];
                sum_q     <= w_out;
                ws_q      <= addr_q;
                addr_q    <= addr_q + ADDR_W'(1);
                out_cnt_q <= out_cnt_q + CNT_W'(1);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_systolic_fir.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_fir
// Purpose  : Table-driven self-checking bench for systolic_fir (both
//            SYSTOLIC_SAT_EN settings), plus address-wrap and reset sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_systolic_fir;
    localparam int NF = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, start, in_valid, coef_we;
    logic signed [7:0] in_data, coef_data;
    logic [1:0]        coef_idx;
    logic              in_ready, we, busy, sys_finish;
    logic [15:0]       sum_out;
    logic [13:0]       ws;

    logic        b_start, b_valid, b_ready, b_we, b_busy, b_fin;
    logic [15:0] b_sum;
    logic [2:0]  b_ws;

    systolic_fir #(.FRAME_LEN(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .coef_we(coef_we),
        .coef_idx(coef_idx), .coef_data(coef_data), .sum_out(sum_out),
        .ws(ws), .we(we), .busy(busy), .sys_finish(sys_finish)
    );

    systolic_fir #(.FRAME_LEN(4), .ADDR_W(3), .BASE_ADDR(6)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_data(in_data),
        .in_valid(b_valid), .in_ready(b_ready), .coef_we(1'b0),
        .coef_idx(2'd0), .coef_data(8'sd0), .sum_out(b_sum),
        .ws(b_ws), .we(b_we), .busy(b_busy), .sys_finish(b_fin)
    );

    typedef struct packed {
        logic              load;
        logic              poke;
        logic [1:0]        gap;
        logic signed [7:0] c0, c1, c2, c3;
    } cfg_t;

    typedef struct packed {
        logic signed [15:0] y;
        logic [13:0]        a;
    } exp_t;

    cfg_t cfg [NF];
    int   X [NF][8];
    int   Y [NF][8];
    int   wrap_exp [4] = '{6, 7, 0, 1};

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   b_n      = 0;
    int   stray    = 0;
    bit   mon_en   = 1'b1;
    bit   post_rst = 1'b0;
    int   acc_q [$];
    exp_t exp_q [$];

    task automatic chk(input string nm, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        if (in_valid && in_ready) acc_q.push_back(cyc);
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (post_rst) begin
            if (we || sys_finish) stray <= stray + 1;
        end else if (mon_en && we) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                chk("unexpected_we", 1, 0);
            end else begin
                chk("sum_out", $signed(sum_out), exp_q[0].y);
                chk("ws", ws, exp_q[0].a);
                chk("we_latency", cyc, acc_q[0] + 2);
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (b_we) begin
            if (b_n < 4) chk("wrap_ws", b_ws, wrap_exp[b_n]);
            else         chk("wrap_extra_we", 1, 0);
            b_n <= b_n + 1;
        end
    end

    task automatic load_coefs(input logic signed [7:0] a, b, c, d);
        logic signed [7:0] v [4];
        v = '{a, b, c, d};
        for (int k = 0; k < 4; k++) begin
            coef_we = 1'b1; coef_idx = 2'(k); coef_data = v[k];
            @(negedge clk);
        end
        coef_we = 1'b0;
    endtask

    task automatic run_frame(input int f);
        exp_t e;
        int   i, budget, gapc;
        if (cfg[f].load) load_coefs(cfg[f].c0, cfg[f].c1, cfg[f].c2, cfg[f].c3);
        for (int k = 0; k < 8; k++) begin
            e.y = 16'(Y[f][k]);
            e.a = 14'(k);
            exp_q.push_back(e);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        i = 0; budget = 0; gapc = 0;
        while (i < 8 && budget < 100) begin
            if (gapc == 0 && in_ready) begin
                in_valid = 1'b1; in_data = 8'(X[f][i]);
                i++; gapc = int'(cfg[f].gap);
            end else begin
                in_valid = 1'b0;
                if (gapc > 0) gapc--;
                if (cfg[f].poke) begin
                    start = 1'b1; coef_we = 1'b1; coef_idx = 2'd0; coef_data = 8'sd99;
                end
            end
            @(negedge clk);
            budget++;
            start = 1'b0; coef_we = 1'b0;
        end
        in_valid = 1'b0;
        chk("samples_accepted", i, 8);
        chk("in_ready_drop", in_ready, 0);
        budget = 0;
        while (!sys_finish && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("sys_finish", sys_finish, 1);
        chk("busy_in_done", busy, 0);
        chk("results_pending", exp_q.size(), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("finish_one_cycle", sys_finish, 0);
        chk("start_in_done_ignored", in_ready, 0);
        @(negedge clk);
        chk("idle_after_frame", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        coef_we = 1'b0; coef_idx = '0; coef_data = '0;
        b_start = 1'b0; b_valid = 1'b0;

        cfg[0] = '{1'b1, 1'b0, 2'd0, 8'sd1,   8'sd0,   8'sd0,   8'sd0};
        cfg[1] = '{1'b1, 1'b0, 2'd0, 8'sd1,   8'sd2,   8'sd3,   8'sd4};
        cfg[2] = '{1'b0, 1'b0, 2'd0, 8'sd0,   8'sd0,   8'sd0,   8'sd0};
        cfg[3] = '{1'b1, 1'b0, 2'd0, 8'sd127, 8'sd127, 8'sd127, 8'sd127};
        cfg[4] = '{1'b1, 1'b1, 2'd2, 8'sd1,   8'sd2,   8'sd3,   8'sd4};
        cfg[5] = '{1'b0, 1'b0, 2'd0, 8'sd0,   8'sd0,   8'sd0,   8'sd0};
        cfg[6] = '{1'b0, 1'b0, 2'd0, 8'sd0,   8'sd0,   8'sd0,   8'sd0};
        X = '{'{1, 2, 3, 4, 5, 6, 7, 8},
              '{1, 0, 0, 0, 0, 0, 0, 0},
              '{5, 0, 0, 0, 0, 0, 0, 0},
              '{127, 127, 127, 127, 127, 127, 127, 127},
              '{1, 0, 0, 0, 0, 0, 0, 0},
              '{0, 0, -2, 1, 0, 0, 0, 0},
              '{1, 2, 3, 4, 5, 6, 7, 8}};
        Y = '{'{1, 2, 3, 4, 5, 6, 7, 8},
              '{1, 2, 3, 4, 0, 0, 0, 0},
              '{5, 10, 15, 20, 0, 0, 0, 0},
`ifdef SYSTOLIC_SAT_EN
              '{16129, 32258, 32767, 32767, 32767, 32767, 32767, 32767},
`else
              '{16129, 32258, -17149, -1020, -1020, -1020, -1020, -1020},
`endif
              '{1, 2, 3, 4, 0, 0, 0, 0},
              '{0, 0, -2, -3, -4, -5, 4, 0},
              '{0, 0, 0, 0, 0, 0, 0, 0}};

        repeat (3) @(negedge clk);
        chk("rst_sum_out", sum_out, 0);
        chk("rst_ws", ws, 0);
        chk("rst_we", we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sys_finish", sys_finish, 0);
        chk("rst_wrap_ws", b_ws, 6);
        rst_n = 1'b1;
        @(negedge clk);

        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            b_valid = 1'b1;
            @(negedge clk);
        end
        b_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("wrap_count", b_n, 4);

        for (int f = 0; f < NF - 1; f++) run_frame(f);

        load_coefs(8'sd1, 8'sd2, 8'sd3, 8'sd4);
        mon_en = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 8'(k + 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        post_rst = 1'b1;
        chk("midrst_sum_out", sum_out, 0);
        chk("midrst_ws", ws, 0);
        chk("midrst_we", we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_sys_finish", sys_finish, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("no_we_after_reset", stray, 0);
        post_rst = 1'b0;
        acc_q.delete();
        exp_q.delete();
        mon_en = 1'b1;
        run_frame(NF - 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/systolic_fir.md
# systolic_fir

Parametrised successor to the single-channel systolic sum engine. It is a transposed-form linear systolic array of NUM_TAPS multiply-accumulate PEs that filters one frame of FRAME_LEN signed samples from `in_data` and writes each result to result memory through the `ws`/`we` port. It pulses `sys_finish` when the last result has been written. Coefficients are loaded between frames.

## Interface
- DATA_W, 8, signed sample and coefficient width
- NUM_TAPS, 4, number of PEs / taps (≥2)
- FRAME_LEN, 16, samples per frame (≥1)
- OUT_W, 16, `sum_out` width (≤ ACC_W)
- ADDR_W, 14, result address width
- BASE_ADDR, 0, first write address of every frame
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  frame start pulse; honoured only in IDLE
- in_data  in  DATA_W  signed sample
- in_valid  in  1  `in_data` valid; sample accepted when `in_valid && state==RUN`
- in_ready  out  1  high in RUN
- coef_we  in  1  coefficient write; honoured only in IDLE
- coef_idx  in  clog2(NUM_TAPS)  tap index
- coef_data  in  DATA_W  signed coefficient
- sum_out  out  OUT_W  result data
- ws  out  ADDR_W  result write address
- we  out  1  result write strobe, one cycle per result
- busy  out  1  high in RUN and DRAIN
- sys_finish  out  1  one-cycle pulse, end of frame

## Operation
- Computes y[n] = Σ c[k]·x[n−k] for k = 0..NUM_TAPS−1 and n = 0..FRAME_LEN−1. x[m<0] = 0: all partial-sum registers clear on `start`.
- ACC_W = 2·DATA_W + clog2(NUM_TAPS). All arithmetic is signed and full precision at ACC_W.
- Output reduction from ACC_W to OUT_W is set by SYSTOLIC_SAT_EN.
- Partial-sum chain advances only on accepted samples. Gaps in `in_valid` stall the chain without corrupting it.
- FSM:
  - IDLE → RUN on `start`.
  - RUN → DRAIN once FRAME_LEN samples have been accepted.
  - DRAIN → DONE on the cycle the last `we` is issued.
  - DONE → IDLE after one cycle. `sys_finish` = 1 in DONE.
- `start` outside IDLE is ignored. `coef_we` outside IDLE is ignored. Coefficients persist across frames.
- `ws` = BASE_ADDR for result 0, then +1 per write, wrapping modulo 2^ADDR_W.
- Reset (any time, including mid-frame):
  - state = IDLE.
  - All coefficients, partial sums and pipeline registers = 0.
  - `sum_out`=0, `ws`=BASE_ADDR, `we`=0, `busy`=0, `in_ready`=0, `sys_finish`=0.
  - The in-progress frame is abandoned with no further writes.

## Timing
- Sample accepted at edge t → `we`=1 with its result on `sum_out`/`ws` in cycle t+2. This is fixed 2-cycle latency: product register, then output register.
- Exactly one `we` per accepted sample, in acceptance order. Never two results per cycle.
- `in_ready` goes high the cycle after `start` is sampled and drops the cycle after the FRAME_LEN-th acceptance.
- `sys_finish` is asserted the cycle after the final `we`. `busy` is low in that cycle.
- `start` in the same cycle as `sys_finish` is ignored. A new `start` is accepted from the following IDLE cycle.
- A coefficient write in IDLE takes effect for the next frame.

## Configuration
- SYSTOLIC_SAT_EN defined: results outside the signed OUT_W range clamp to +(2^(OUT_W−1)−1) or −2^(OUT_W−1).
- SYSTOLIC_SAT_EN undefined: `sum_out` = low OUT_W bits of the accumulator (two's-complement wrap).

## Test plan
- Identity:
  - Stimulus: coefs {1,0,0,0}, FRAME_LEN=8, inputs 1..8 with continuous `in_valid`.
  - Response: `sum_out` 1..8 at `ws` 0..7, first `we` 2 cycles after the first acceptance.
  - Then `sys_finish` for exactly one cycle.
- Impulse:
  - Stimulus: coefs {1,2,3,4}, inputs {1,0,0,0,0,0,0,0}.
  - Response: outputs 1,2,3,4,0,0,0,0.
  - Second frame, inputs {5,0,…}: outputs 5,10,15,20,0,0,0,0. This confirms history is cleared at frame start.
- Saturation:
  - Stimulus: coefs all 127, inputs all 127, OUT_W=16.
  - Response, with SYSTOLIC_SAT_EN: outputs 16129, 32258, 32767, 32767, …
  - Response, without SYSTOLIC_SAT_EN: 16129, 32258, −17149, −1020, …
- Stalls:
  - Stimulus: the impulse frame with `in_valid` toggling 1,0,0,1,… and `start`/`coef_we` pulsed mid-frame.
  - Response: identical result sequence and addresses, each `we` 2 cycles after its acceptance.
  - The mid-frame `start`/`coef_we` have no effect.
- Wrap:
  - Stimulus: ADDR_W=3, BASE_ADDR=6, FRAME_LEN=4.
  - Response: `ws` = 6, 7, 0, 1.
- Reset mid-frame:
  - Stimulus: `rst_n` low after 3 acceptances.
  - Response: all outputs 0 and `ws`=BASE_ADDR immediately, with no `we` or `sys_finish` afterwards.
  - A fresh `start` gives all-zero results, since coefficients were cleared.
